// File: rtl/sync_sample_ctrl.sv
// syncUnit controller: drives its config/reset/override inputs and turns
// its sample pulses into decided bits (single sample or 2-of-3 vote).
module sync_sample_ctrl #(
  parameter int DEFAULT_PERIOD = 100,
  parameter int HOLD_CYCLES    = 2,
  parameter int IDLE_BITS      = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfgValid,
  output logic        cfgReady,
  input  logic [22:0] cfgPeriod,
  input  logic        cfgMulti,
  input  logic        cfgResyncEn,
  input  logic        txActive,
  input  logic        canClk,
  input  logic        samplePulse,
  input  logic        sampleVal,
  output logic        suResetN,
  output logic [22:0] suBitPeriod,
  output logic        suMulti,
  output logic        suOverride,
  output logic        bitValid,
  output logic        bitValue,
  output logic        voteErr,
  output logic        cfgErr,
  output logic        busIdle
);

  localparam int IW = $clog2(IDLE_BITS + 1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_BITS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    APPLY = 2'd2
  } state_t;

  state_t        state;
  logic [HW-1:0] holdCnt;
  logic          resyncEn;
  logic [IW-1:0] idleCnt;
  logic [IW-1:0] idleNext;
  logic [1:0]    sampCnt;
  logic [1:0]    baseCnt;
  logic          samp0;
  logic          samp1;
  logic          canClkQ;
  logic          canRise;
  logic          cfgHs;
  logic          applyGo;
  logic          inRun;
  logic          allSame;

  assign inRun    = (state == RUN);
  assign suResetN = inRun;
  assign cfgReady = inRun & busIdle;
  assign cfgHs    = cfgValid & cfgReady;
  assign applyGo  = cfgHs & (cfgPeriod != '0);

  assign suOverride = ~inRun | txActive
                    | (~resyncEn & ~busIdle);

  assign canRise = canClk & ~canClkQ;
  assign baseCnt = canRise ? 2'd0 : sampCnt;
  assign allSame = (samp0 == samp1)
                 & (samp1 == sampleVal);

  // Reset/apply sequencing and configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HOLD;
      holdCnt     <= '0;
      suBitPeriod <= 23'(DEFAULT_PERIOD);
      suMulti     <= 1'b0;
      resyncEn    <= 1'b1;
      cfgErr      <= 1'b0;
    end else begin
      cfgErr <= 1'b0;
      unique case (state)
        HOLD, APPLY: begin
          if (holdCnt == HOLD_LAST) begin
            state   <= RUN;
            holdCnt <= '0;
          end else begin
            holdCnt <= holdCnt + 1'b1;
          end
        end
        RUN: begin
          if (cfgHs) begin
            if (cfgPeriod == '0) begin
              cfgErr <= 1'b1;
            end else begin
              state       <= APPLY;
              holdCnt     <= '0;
              suBitPeriod <= cfgPeriod;
              suMulti     <= cfgMulti;
              resyncEn    <= cfgResyncEn;
            end
          end
        end
        default: begin
          state   <= HOLD;
          holdCnt <= '0;
        end
      endcase
    end
  end

  // Bit decision from sample pulses, framed by canClk rising edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      canClkQ  <= 1'b0;
      sampCnt  <= 2'd0;
      samp0    <= 1'b0;
      samp1    <= 1'b0;
      bitValid <= 1'b0;
      bitValue <= 1'b1;
      voteErr  <= 1'b0;
    end else begin
      canClkQ  <= canClk;
      bitValid <= 1'b0;
      voteErr  <= 1'b0;
      if (!inRun || applyGo) begin
        sampCnt <= 2'd0;
      end else begin
        if (canRise) begin
          sampCnt <= 2'd0;
          if (suMulti && sampCnt != 2'd0)
            voteErr <= 1'b1;
        end
        if (samplePulse) begin
          if (!suMulti) begin
            bitValid <= 1'b1;
            bitValue <= sampleVal;
          end else begin
            case (baseCnt)
              2'd1: begin
                samp1   <= sampleVal;
                sampCnt <= 2'd2;
              end
              2'd2: begin
                bitValid <= 1'b1;
                bitValue <= (samp0 & samp1)
                          | (samp0 & sampleVal)
                          | (samp1 & sampleVal);
                voteErr  <= ~allSame;
                sampCnt  <= 2'd0;
              end
              default: begin
                samp0   <= sampleVal;
                sampCnt <= 2'd1;
              end
            endcase
          end
        end
      end
    end
  end

  // Saturating count of consecutive recessive bits.
  always_comb begin
    idleNext = '0;
    if (bitValue)
      idleNext = (idleCnt == IDLE_MAX) ? idleCnt
                                       : idleCnt + 1'b1;
  end

  // Bus idle tracking, cleared outside RUN and on config apply.
  always_ff @(posedge clk) begin
    if (reset) begin
      idleCnt <= '0;
      busIdle <= 1'b0;
    end else if (!inRun || applyGo) begin
      idleCnt <= '0;
      busIdle <= 1'b0;
    end else if (bitValid) begin
      idleCnt <= idleNext;
      busIdle <= (idleNext == IDLE_MAX);
    end
  end

endmodule
